ccff_chain_loader: RTL and testbench

Serial configuration-chain driver for the `ccff_head`/`ccff_tail` shift chains that program the switch-block and connection-block routing muxes. It accepts configuration words from the bitstream controller over a valid/ready handshake and serializes them, LSB first, onto `ccff_head`. It issues a per-cycle shift enable that gates `prog_clk` to the chain. With the readback feature compiled in, it then rotates the chain once and checks integrity from `ccff_tail` with a CRC.

---
 rtl/ccff_chain_loader_if.sv | 21 ++
 rtl/ccff_chain_loader.sv | 172 +++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccff_chain_loader_if.sv
// Word handshake between the bitstream controller (master) and the
// configuration-chain loader (slave).
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
) ();
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_in,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_in,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serial driver for the ccff_head/ccff_tail configuration chain.
// Words are taken over a valid/ready handshake and shifted out LSB first,
// with shift_en acting as the chain clock enable.
// Optional feature macro: CCFF_READBACK_EN adds a recirculating readback
// pass with a CRC-16-CCITT integrity check that drives error.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | word_ready high, chain holds, waiting for a word
// SHIFT  | one word bit onto ccff_head per cycle, shift_en high
// VERIFY | chain rotated once through ccff_tail -> ccff_head (readback only)
// DONE   | one-cycle done pulse
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic                      prog_clk,
    input  logic                      prog_reset_n,
    input  logic                      start,
    ccff_chain_loader_if.slave        word_bus,
    output logic                      ccff_head,
    output logic                      shift_en,
    input  logic                      ccff_tail,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam int BIT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] SENT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(WORD_W - 1);

`ifdef CCFF_READBACK_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_SHIFT, ST_VERIFY, ST_DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE
    } state_t;
`endif

    state_t            state;
    logic              ready_q;
    logic              head_q;
    logic [WORD_W-1:0] sreg;
    logic [CNT_W-1:0]  sent;
    logic [BIT_W-1:0]  bit_cnt;

`ifdef CCFF_READBACK_EN
    logic [15:0]       crc_tx;
    logic [15:0]       crc_rb;
    logic [CNT_W-1:0]  rb_cnt;
    logic              in_verify;
    logic              error_q;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // During VERIFY the tail is looped straight back to the head so the
    // rotation needs no extra stage and the chain returns to its start image.
    assign ccff_head = in_verify ? ccff_tail : head_q;
    assign error     = error_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign ccff_head   = head_q;
    assign error       = 1'b0;
`endif

    assign word_bus.word_ready = ready_q;

    // Sequencer: state, counters, shift register and all registered outputs.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b0;
            head_q   <= 1'b0;
            shift_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sreg     <= '0;
            sent     <= '0;
            bit_cnt  <= '0;
`ifdef CCFF_READBACK_EN
            crc_tx    <= 16'hFFFF;
            crc_rb    <= 16'hFFFF;
            rb_cnt    <= '0;
            in_verify <= 1'b0;
            error_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sent    <= '0;
                        ready_q <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_LOAD;
`ifdef CCFF_READBACK_EN
                        crc_tx  <= 16'hFFFF;
                        error_q <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (word_bus.word_valid && ready_q) begin
                        ready_q  <= 1'b0;
                        sreg     <= word_bus.word_in >> 1;
                        head_q   <= word_bus.word_in[0];
                        shift_en <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sent <= sent + CNT_W'(1);
`ifdef CCFF_READBACK_EN
                    crc_tx <= crc_step(crc_tx, head_q);
`endif
                    if (sent == SENT_LAST) begin
                        head_q <= 1'b0;
`ifdef CCFF_READBACK_EN
                        in_verify <= 1'b1;
                        crc_rb    <= 16'hFFFF;
                        rb_cnt    <= '0;
                        state     <= ST_VERIFY;
`else
                        shift_en <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
`endif
                    end else if (bit_cnt == WORD_LAST) begin
                        shift_en <= 1'b0;
                        head_q   <= 1'b0;
                        ready_q  <= 1'b1;
                        state    <= ST_LOAD;
                    end else begin
                        head_q  <= sreg[0];
                        sreg    <= sreg >> 1;
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
`ifdef CCFF_READBACK_EN
                ST_VERIFY: begin
                    crc_rb <= crc_step(crc_rb, ccff_tail);
                    if (rb_cnt == SENT_LAST) begin
                        shift_en  <= 1'b0;
                        in_verify <= 1'b0;
                        error_q   <= (crc_step(crc_rb, ccff_tail) != crc_tx);
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        rb_cnt <= rb_cnt + CNT_W'(1);
                    end
                end
`endif
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 16-bit and a 10-bit chain instance, each
// driving a behavioural DFF chain model; expected head bits are queued at
// word acceptance and popped on every shift cycle.
module tb_ccff_chain_loader;

`ifdef CCFF_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start16 = 1'b0;
    logic start10 = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic w_valid = 1'b0;
    bit stuck7 = 1'b0;

    logic head16, se16, busy16, done16, err16;
    logic head10, se10, busy10, done10, err10;
    logic [15:0] chain16 = '0;
    logic [9:0]  chain10 = '0;
    logic tail16, tail10;

    int n_checks = 0;
    int n_fail = 0;
    int edge_cnt = 0;
    int sh16 = 0, vc16 = 0, sh10 = 0, vc10 = 0;
    logic q16[$];
    logic q10[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    ccff_chain_loader_if #(.WORD_W(8)) bus16 ();
    ccff_chain_loader_if #(.WORD_W(8)) bus10 ();
    assign bus16.word_in = w_data;
    assign bus16.word_valid = w_valid;
    assign bus10.word_in = w_data;
    assign bus10.word_valid = w_valid;

    assign tail16 = chain16[15];
    assign tail10 = chain10[9];

    ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8), .CNT_W(16)) u16 (
        .prog_clk(clk), .prog_reset_n(rst_n), .start(start16), .word_bus(bus16),
        .ccff_head(head16), .shift_en(se16), .ccff_tail(tail16),
        .busy(busy16), .done(done16), .error(err16)
    );

    ccff_chain_loader #(.CHAIN_LEN(10), .WORD_W(8), .CNT_W(16)) u10 (
        .prog_clk(clk), .prog_reset_n(rst_n), .start(start10), .word_bus(bus10),
        .ccff_head(head10), .shift_en(se10), .ccff_tail(tail10),
        .busy(busy10), .done(done10), .error(err10)
    );

    // chain model: index 0 is next to ccff_head, top index drives ccff_tail
    always @(posedge clk) begin : chain_model
        logic [15:0] nxt;
        if (se16) begin
            nxt = {chain16[14:0], head16};
            if (stuck7) nxt[7] = 1'b0;
            chain16 <= nxt;
        end
        if (se10) chain10 <= {chain10[8:0], head10};
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (se16) begin
                if (q16.size() > 0) begin
                    check_val("head16", head16, q16.pop_front());
                    sh16++;
                end else begin
                    vc16++;
                    check_val("recirc16", head16, tail16);
                end
            end
            if (se10) begin
                if (q10.size() > 0) begin
                    check_val("head10", head10, q10.pop_front());
                    sh10++;
                end else begin
                    vc10++;
                    check_val("recirc10", head10, tail10);
                end
            end
        end
    end

    function automatic logic rdy(input bit s);
        return s ? bus10.word_ready : bus16.word_ready;
    endfunction
    function automatic logic se(input bit s);
        return s ? se10 : se16;
    endfunction
    function automatic logic dn(input bit s);
        return s ? done10 : done16;
    endfunction
    function automatic logic bsy(input bit s);
        return s ? busy10 : busy16;
    endfunction

    function automatic logic [15:0] exp_chain(input logic [15:0] s);
        logic [15:0] r;
        for (int k = 0; k < 16; k++) r[15-k] = s[k];
        return r;
    endfunction

    task automatic run_load(input bit sel, input logic [7:0] w0, input logic [7:0] w1,
                            input bit stall, input bit poke, output int done_cyc);
        int len, pushed, e0;
        logic [7:0] w;
        bit got;
        len = sel ? 10 : 16;
        pushed = 0;
        sh16 = 0; vc16 = 0; sh10 = 0; vc10 = 0;
        @(posedge clk); #1;
        if (sel) start10 = 1'b1; else start16 = 1'b1;
        @(posedge clk); #1;
        e0 = edge_cnt;
        start10 = 1'b0; start16 = 1'b0;
        check_val("ready_lat", rdy(sel), 1'b1);
        for (int i = 0; i < 2; i++) begin
            w = (i == 0) ? w0 : w1;
            if (i == 1 && stall) begin
                w_valid = 1'b0;
                got = 1'b0;
                for (int k = 0; k < 40 && !got; k++) begin
                    @(negedge clk);
                    got = rdy(sel);
                end
                check_val("stall_reach", got, 1'b1);
                for (int k = 0; k < 5; k++) begin
                    check_val("stall_se", se(sel), 1'b0);
                    check_val("stall_rdy", rdy(sel), 1'b1);
                    if (k < 4) @(negedge clk);
                end
                @(posedge clk); #1;
            end
            w_data = w;
            w_valid = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                got = rdy(sel);
            end
            check_val("accept", got, 1'b1);
            @(posedge clk);
            for (int b = 0; b < 8 && pushed < len; b++) begin
                if (sel) q10.push_back(w[b]); else q16.push_back(w[b]);
                pushed++;
            end
            #1;
        end
        w_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = dn(sel);
        end
        check_val("done_seen", got, 1'b1);
        done_cyc = edge_cnt - e0 + 1;
        if (poke) begin
            if (sel) start10 = 1'b1; else start16 = 1'b1;
            @(posedge clk); #1;
            start10 = 1'b0; start16 = 1'b0;
        end
        @(negedge clk);
        check_val("done_pulse", dn(sel), 1'b0);
        check_val("idle_busy", bsy(sel), 1'b0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        int dc;
        logic [15:0] exp16;
        bit got;
        exp16 = exp_chain({8'h3C, 8'hA5});

        #12;
        check_val("rst_ready16", bus16.word_ready, 1'b0);
        check_val("rst_head16", head16, 1'b0);
        check_val("rst_se16", se16, 1'b0);
        check_val("rst_busy16", busy16, 1'b0);
        check_val("rst_done16", done16, 1'b0);
        check_val("rst_err16", err16, 1'b0);
        check_val("rst_se10", se10, 1'b0);
        #10 rst_n = 1'b1;

        // 16-bit load, word_valid held high (with readback when compiled in)
        run_load(1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, dc);
        check_val("done_cyc16", dc, 19 + RB * 16);
        check_val("shifts16", sh16, 16);
        check_val("recirc_cnt16", vc16, RB * 16);
        check_val("chain16", chain16, exp16);
        check_val("err16_pass", err16, 1'b0);

        // stall before the second word, plus start poked during done
        run_load(1'b0, 8'hA5, 8'h3C, 1'b1, 1'b1, dc);
        check_val("shifts16_stall", sh16, 16);
        check_val("chain16_stall", chain16, exp16);
        @(negedge clk);
        check_val("start_in_done_ignored", busy16, 1'b0);
        check_val("no_ready_after_done", bus16.word_ready, 1'b0);

        // partial last word on a 10-bit chain
        run_load(1'b1, 8'hFF, 8'hFE, 1'b0, 1'b0, dc);
        check_val("shifts10", sh10, 10);
        check_val("done_cyc10", dc, 13 + RB * 10);
        check_val("chain10", chain10, 10'h3FD);
        check_val("recirc_cnt10", vc10, RB * 10);

        // reset asserted in the 4th shift cycle
        @(posedge clk); #1 start16 = 1'b1;
        @(posedge clk); #1 start16 = 1'b0;
        sh16 = 0;
        w_data = 8'h3C;
        w_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = bus16.word_ready;
        end
        check_val("rst_accept", got, 1'b1);
        @(posedge clk);
        for (int b = 0; b < 8; b++) q16.push_back(w_data[b]);
        #1 w_valid = 1'b0;
        for (int k = 0; k < 40 && sh16 < 4; k++) begin
            @(negedge clk);
            #1;
        end
        check_val("rst_reach", sh16, 4);
        check_val("pre_rst_head", head16, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("async_se", se16, 1'b0);
        check_val("async_busy", busy16, 1'b0);
        check_val("async_head", head16, 1'b0);
        q16.delete();
        #1 rst_n = 1'b1;
        run_load(1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, dc);
        check_val("reload_chain16", chain16, exp16);
        check_val("reload_done_cyc", dc, 19 + RB * 16);

`ifdef CCFF_READBACK_EN
        // readback with chain DFF 7 stuck at 0
        stuck7 = 1'b1;
        run_load(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, dc);
        check_val("err_set", err16, 1'b1);
        repeat (5) @(negedge clk);
        check_val("err_sticky", err16, 1'b1);
        stuck7 = 1'b0;
        @(posedge clk); #1 start16 = 1'b1;
        @(posedge clk); #1 start16 = 1'b0;
        check_val("err_cleared", err16, 1'b0);
        check_val("busy_after_start", busy16, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
